// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the iterative multiply/divide unit.
// Contents:
//   OP_MULT / OP_MULTU / OP_DIV / OP_DIVU : 2-bit operation encodings
//   state_t                               : sequencer states (IDLE, CALC, FIX)
// Encoding detail relied on by the datapath:
//   op[1] = 1 selects divide, op[0] = 0 selects signed operands.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit -- MIPS-style HI/LO multiply/divide unit, one radix-2 step per
// cycle (shift-add multiply, restoring divide on operand magnitudes).
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   start, op, a, b : request (sampled only in IDLE), operation, operands
//   hi_we, lo_we    : mthi/mtlo strobes, honoured only in IDLE with start=0
//   wdata           : mthi/mtlo data
//   busy, done      : operation in progress / one-cycle completion pulse
//   dbz             : last divide had a zero divisor (cleared by next start)
//   hi, lo          : architectural HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONES_W  = {WIDTH{1'b1}};
  localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_LD  = CNT_W'(WIDTH);

  // Two's complement magnitude of v when neg is set, v itself otherwise.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
    mag = neg ? (~v + ONE_W) : v;
  endfunction

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               is_div_r, neg_q_r, neg_r_r, bz_r;
  logic [WIDTH-1:0]   a_r;
  // Multiply: acc_r = running upper half, lo_acc_r = multiplier shifting out / product low half.
  // Divide:   acc_r = partial remainder,  lo_acc_r = dividend shifting out / quotient bits in.
  logic [WIDTH:0]     acc_r;
  logic [WIDTH-1:0]   lo_acc_r;
  logic [WIDTH-1:0]   opnd_r;  // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               dbz_r, busy_r, done_r;

  logic               a_neg_s, b_neg_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
  logic [WIDTH:0]     acc_nx_s;
  logic [WIDTH-1:0]   lo_nx_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;

  assign busy = busy_r;
  assign done = done_r;
  assign dbz  = dbz_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // Operand sign extraction at request time; unsigned ops never count as negative.
  always_comb begin
    a_neg_s = ~op[0] & a[WIDTH-1];
    b_neg_s = ~op[0] & b[WIDTH-1];
  end

  // One radix-2 iteration for either operation.
  always_comb begin
    mul_sum_s   = acc_r + {1'b0, (lo_acc_r[0] ? opnd_r : ZERO_W)};
    div_shift_s = {acc_r[WIDTH-1:0], lo_acc_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    acc_nx_s    = acc_r;
    lo_nx_s     = lo_acc_r;
    if (is_div_r) begin
      // Restoring step: keep the difference only when it did not borrow.
      if (!div_diff_s[WIDTH]) begin
        acc_nx_s = div_diff_s;
        lo_nx_s  = {lo_acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx_s = div_shift_s;
        lo_nx_s  = {lo_acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift the (sum, multiplier) pair right by one; the sum's LSB becomes a product bit.
      acc_nx_s = {1'b0, mul_sum_s[WIDTH:1]};
      lo_nx_s  = {mul_sum_s[0], lo_acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction and final HI/LO selection once all iterations are done.
  always_comb begin
    prod_s   = {acc_r[WIDTH-1:0], lo_acc_r};
    fix_hi_s = hi_r;
    fix_lo_s = lo_r;
    if (neg_q_r) begin
      prod_s = ~prod_s + ONE_2W;
    end else begin
      prod_s = {acc_r[WIDTH-1:0], lo_acc_r};
    end
    if (is_div_r) begin
      if (bz_r) begin
        fix_hi_s = a_r;
        fix_lo_s = ONES_W;
      end else begin
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        // Most-negative / -1 falls out naturally: magnitude quotient 2^(W-1), positive sign.
        fix_hi_s = mag(acc_r[WIDTH-1:0], neg_r_r);
        fix_lo_s = mag(lo_acc_r, neg_q_r);
      end
    end else begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Next-state logic: CALC runs WIDTH steps plus one terminal cycle, FIX lasts one cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = FIX;
        end else begin
          state_s = CALC;
        end
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == FIX);
    end
  end

  // Datapath: operand capture, iteration, result write-back and mthi/mtlo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= {CNT_W{1'b0}};
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      bz_r     <= 1'b0;
      a_r      <= ZERO_W;
      acc_r    <= {(WIDTH+1){1'b0}};
      lo_acc_r <= ZERO_W;
      opnd_r   <= ZERO_W;
      hi_r     <= ZERO_W;
      lo_r     <= ZERO_W;
      dbz_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r    <= CNT_LD;
            is_div_r <= op[1];
            neg_q_r  <= a_neg_s ^ b_neg_s;
            neg_r_r  <= a_neg_s;
            bz_r     <= (b == ZERO_W);
            a_r      <= a;
            acc_r    <= {(WIDTH+1){1'b0}};
            dbz_r    <= 1'b0;
            if (op[1]) begin
              lo_acc_r <= mag(a, a_neg_s);
              opnd_r   <= mag(b, b_neg_s);
            end else begin
              lo_acc_r <= mag(b, b_neg_s);
              opnd_r   <= mag(a, a_neg_s);
            end
          end else begin
            if (hi_we) begin
              hi_r <= wdata;
            end
            if (lo_we) begin
              lo_r <= wdata;
            end
          end
        end
        CALC: begin
          if (cnt_r != {CNT_W{1'b0}}) begin
            acc_r    <= acc_nx_s;
            lo_acc_r <= lo_nx_s;
            cnt_r    <= cnt_r - CNT_ONE;
          end else begin
            // Results land on the edge that enters FIX so they are valid while done is high.
            hi_r  <= fix_hi_s;
            lo_r  <= fix_lo_s;
            dbz_r <= is_div_r & bz_r;
          end
        end
        FIX: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed + random self-checking bench for muldiv_unit
// (WIDTH=32). Expected results come from a behavioural 64-bit model, are
// queued when a request is driven and popped when done is observed.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = 32'h0, b = 32'h0, wdata = 32'h0;
  logic         hi_we = 1'b0, lo_we = 1'b0;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];
  logic [W-1:0] cur_hi = 32'h0, cur_lo = 32'h0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint sx, sy, sq, sr;
    logic [63:0] p;
    e.dbz = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      OP_MULT: begin
        p = 64'(sx * sy);
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      OP_MULTU: begin
        p = {32'h0, x} * {32'h0, y};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      OP_DIV: begin
        if (y == 32'h0) begin
          e.hi = x; e.lo = 32'hFFFFFFFF; e.dbz = 1'b1;
        end else begin
          sq = sx / sy; sr = sx % sy;
          e.hi = sr[31:0]; e.lo = sq[31:0];
        end
      end
      default: begin
        if (y == 32'h0) begin
          e.hi = x; e.lo = 32'hFFFFFFFF; e.dbz = 1'b1;
        end else begin
          e.hi = x % y; e.lo = x / y;
        end
      end
    endcase
    return e;
  endfunction

  // Issue one request and follow it to completion (or to an injected reset).
  // ign_at / hiwe_at / rst_at: CALC cycle index at which to inject an ignored
  // start, an mthi write, or a reset (-1 = never). hiwe_start: mthi alongside start.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int ign_at, input int hiwe_at, input int rst_at, input logic hiwe_start);
    exp_t e;
    int   cyc, busy_n;
    logic aborted, hold_ok, extra_done;
    exp_q.push_back(model(o, x, y));
    start = 1'b1; op = o; a = x; b = y;
    if (hiwe_start) begin
      hi_we = 1'b1; wdata = 32'hABCD0000;
    end
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    check("accept_busy", {63'h0, busy}, 64'h1);
    check("accept_dbz_clr", {63'h0, dbz}, 64'h0);
    check("accept_hi_hold", {32'h0, hi}, {32'h0, cur_hi});
    cyc = 0; busy_n = busy ? 1 : 0; aborted = 1'b0; hold_ok = 1'b1;
    while (!done && cyc < 100 && !aborted) begin
      if (cyc == ign_at) begin
        start = 1'b1; op = OP_MULTU; a = 32'h3; b = 32'h5;
      end
      if (cyc == hiwe_at) begin
        hi_we = 1'b1; wdata = 32'hDEADBEEF;
      end
      if (cyc == rst_at) begin
        rst = 1'b1; #1;
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_dbz",  {63'h0, dbz},  64'h0);
        check("rst_hilo", {hi, lo}, 64'h0);
        aborted = 1'b1;
      end else begin
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        cyc++;
        if (busy) busy_n++;
        if (!done && (hi !== cur_hi || lo !== cur_lo)) hold_ok = 1'b0;
      end
    end
    check("calc_hilo_hold", {63'h0, hold_ok}, 64'h1);
    if (aborted) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      cur_hi = 32'h0; cur_lo = 32'h0;
      extra_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (done || busy) extra_done = 1'b1;
      end
      check("abort_no_done", {63'h0, extra_done}, 64'h0);
    end else begin
      check("done_seen", {63'h0, done}, 64'h1);
      check("latency", 64'(cyc), 64'd33);
      check("busy_cycles", 64'(busy_n), 64'd34);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("res_hi", {32'h0, hi}, {32'h0, e.hi});
        check("res_lo", {32'h0, lo}, {32'h0, e.lo});
        check("res_dbz", {63'h0, dbz}, {63'h0, e.dbz});
        cur_hi = e.hi; cur_lo = e.lo;
      end else begin
        check("queue_nonempty", 64'h0, 64'h1);
      end
      @(posedge clk); #1;
      check("done_single", {63'h0, done}, 64'h0);
      check("idle_busy", {63'h0, busy}, 64'h0);
    end
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    #12;
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_dbz",  {63'h0, dbz},  64'h0);
    check("reset_hilo", {hi, lo}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // mthi / mtlo in IDLE
    hi_we = 1'b1; wdata = 32'h00001234;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check("mthi_idle", {32'h0, hi}, 64'h00001234);
    lo_we = 1'b1; wdata = 32'h00005678;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mtlo_idle", {32'h0, lo}, 64'h00005678);
    cur_hi = 32'h00001234; cur_lo = 32'h00005678;

    // start wins over a simultaneous mthi
    do_op(OP_MULT, 32'hFFFFFFFD, 32'h00000007, -1, -1, -1, 1'b1);
    check("mult_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, -1, 1'b0);
    check("multu_max_const", {hi, lo}, 64'hFFFFFFFE_00000001);
    do_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, -1, 1'b0);
    check("mult_m1_const", {hi, lo}, 64'h00000000_00000001);

    do_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, -1, -1, -1, 1'b0);
    check("div_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(OP_DIVU, 32'h00000007, 32'h00000002, -1, -1, -1, 1'b0);
    check("divu_const", {hi, lo}, 64'h00000001_00000003);
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, -1, -1, 1'b0);
    check("div_ovf_const", {hi, lo}, 64'h00000000_80000000);

    do_op(OP_DIV, 32'h00000005, 32'h00000000, -1, -1, -1, 1'b0);
    check("dbz_const", {hi, lo, 31'h0, dbz}, {64'h00000005_FFFFFFFF, 32'h1});
    repeat (3) @(posedge clk);
    #1;
    check("dbz_sticky", {63'h0, dbz}, 64'h1);
    // accept-edge dbz clear is checked inside do_op
    do_op(OP_MULT, 32'h00000003, 32'h00000004, -1, -1, -1, 1'b0);

    // ignored start at CALC cycle 10, mthi during busy at cycle 5
    do_op(OP_MULTU, 32'h12345678, 32'h9ABCDEF0, 10, 5, -1, 1'b0);

    // reset mid-CALC, then a fresh operation
    do_op(OP_DIVU, 32'hCAFEBABE, 32'h00000013, -1, -1, 12, 1'b0);
    do_op(OP_DIV, 32'h7FFFFFFF, 32'hFFFFFFF0, -1, -1, -1, 1'b0);

    // random mix, with a few zero / minus-one divisors
    for (int i = 0; i < 10; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i == 3) rb = 32'h0;
      if (i == 5) rb = 32'hFFFFFFFF;
      if (i == 7) rb = 32'($urandom_range(1, 15));
      do_op(ro, ra, rb, -1, -1, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand, HI and LO width (even, >= 4).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, meaning iteration counter width.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start.
REQ-007 a  input  WIDTH  rs operand (multiplicand / dividend).
REQ-008 b  input  WIDTH  rt operand (multiplier / divisor).
REQ-009 hi_we  input  1  mthi write strobe.
REQ-010 lo_we  input  1  mtlo write strobe.
REQ-011 wdata  input  WIDTH  mthi/mtlo data.
REQ-012 busy  output  1  operation in progress.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 dbz  output  1  last divide had zero divisor; sticky until the next accepted start.
REQ-015 hi  output  WIDTH  HI register.
REQ-016 lo  output  WIDTH  LO register.

Function
REQ-017 SHALL implement FSM IDLE -> CALC -> FIX -> IDLE; encodings in package.
REQ-018 IDLE: start=1 at a rising edge SHALL latch op, a and b, clear dbz, load counter = WIDTH, and move to CALC.
REQ-019 CALC SHALL perform one radix-2 step per cycle (shift-add multiply; restoring divide on magnitudes) and decrement the counter; at zero it SHALL move to FIX.
REQ-020 FIX SHALL apply sign correction, write hi/lo, assert done for that cycle, and return to IDLE.
REQ-021 busy SHALL be 1 in CALC and FIX, 0 in IDLE; done SHALL be 1 only in FIX.
REQ-022 Latency: start accepted at edge N -> hi/lo valid and done high after edge N+WIDTH+1; next start is accepted at edge N+WIDTH+2.
REQ-023 start while busy SHALL be ignored; no queueing.
REQ-024 mult/multu: {hi,lo} SHALL equal the full 2*WIDTH product, signed (two's complement) or unsigned.
REQ-025 div/divu: lo = quotient, hi = remainder; signed quotient truncates toward zero; remainder takes dividend's sign.
REQ-026 Signed overflow (a = most negative, b = -1): lo = most negative, hi = 0, no flag.
REQ-027 b = 0 on div/divu: lo = all ones, hi = a, dbz = 1, same latency as a normal divide.
REQ-028 hi_we/lo_we SHALL update hi/lo at the edge only in IDLE with start=0; ignored otherwise (start wins over a simultaneous write).
REQ-029 hi/lo SHALL hold their values between operations and during CALC; they change only in FIX, on an mthi/mtlo write, or on reset.

Reset
REQ-030 rst=1 SHALL asynchronously force IDLE, busy=0, done=0, dbz=0, hi=0, lo=0, counter=0.
REQ-031 Reset mid-operation SHALL abort without a done pulse; the first start after release behaves as a fresh operation.

Structure
REQ-032 Package muldiv_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the state enum (IDLE, CALC, FIX).
REQ-033 The datapath SHALL be in a single module; no sub-module is required.
REQ-034 SHALL be synthesizable, with no '*', '/' or '%' operators on WIDTH-wide operands.

Verification (WIDTH=32)
REQ-035 mult a=FFFFFFFD b=00000007 -> hi=FFFFFFFF lo=FFFFFFEB; done exactly 33 cycles after the start edge; busy high for 34 cycles.
REQ-036 multu a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE lo=00000001; mult with the same operands -> hi=0 lo=1.
REQ-037 div a=FFFFFFF9 b=2 -> lo=FFFFFFFD hi=FFFFFFFF; divu a=7 b=2 -> lo=3 hi=1; div a=80000000 b=FFFFFFFF -> lo=80000000 hi=0.
REQ-038 div a=5 b=0 -> lo=FFFFFFFF hi=5 dbz=1; next mult start -> dbz cleared on the accept edge.
REQ-039 start pulsed at cycle 10 of a busy op -> ignored, single done; hi_we during busy -> hi unchanged; hi_we in IDLE wdata=1234 -> hi=00001234.
REQ-040 rst asserted mid-CALC -> immediate IDLE, hi=lo=0, no done; new start after release -> correct result with nominal latency.
